// File: rtl/wb_pad_pkg.sv
// Shared definitions for the Wishbone pad controller: register map,
// decode window and the full-width pad vector type.
package wb_pad_pkg;

  // Register indices; the byte offset of a register is index * 8.
  localparam logic [2:0] REG_SEL    = 3'd0;
  localparam logic [2:0] REG_OUT    = 3'd1;
  localparam logic [2:0] REG_OE     = 3'd2;
  localparam logic [2:0] REG_IN     = 3'd3;
  localparam logic [2:0] REG_RISE   = 3'd4;
  localparam logic [2:0] REG_IRQ_EN = 3'd5;

  // Decoded window, and the first offset past the last register.
  localparam logic [31:0] WINDOW_SIZE  = 32'h0000_0040;
  localparam logic [5:0]  MAPPED_LIMIT = 6'h30;

  // Every register is held at the maximum pad count.
  typedef logic [63:0] pad_vec_t;

  // Byte-lane write merge: bits under mask take the new value.
  function automatic pad_vec_t merge_bytes(input pad_vec_t old_v,
                                           input pad_vec_t new_v,
                                           input pad_vec_t mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

endpackage

// File: rtl/wb_pad_ctrl_pad_sync_edge.sv
// Pad input synchroniser with one extra delay stage and rising-edge
// detect. Edges are suppressed until the chain has filled after reset,
// so pads that are already high at reset release do not report a rise.
module pad_sync_edge #(
  parameter int WIDTH       = 38,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise
);

  localparam int ARM_COUNT = SYNC_STAGES + 1;
  localparam int CW        = $clog2(ARM_COUNT + 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0]                  prev_q;
  logic [CW-1:0]                     arm_cnt_q;
  logic                              armed;

  assign armed = (arm_cnt_q == CW'(ARM_COUNT));
  assign q     = sync_q[SYNC_STAGES-1];
  assign rise  = q & ~prev_q & {WIDTH{armed}};

  // Shift pad inputs through the chain and count off the arming delay.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the chain is reset because its contents are visible through IN
    // and feed edge detection; a don't-care start would read back garbage.
    if (!rst_n) begin
      sync_q    <= '0;
      prev_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample the old value
      // of its neighbour, which is what makes this a shift register.
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= q;
      if (!armed) arm_cnt_q <= arm_cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/wb_pad_ctrl.sv
// Wishbone-controlled pad multiplexer. Each pad can be taken from the core
// and handed to software GPIO with synchronised readback, sticky rising-edge
// flags and a maskable level interrupt.
module wb_pad_ctrl
  import wb_pad_pkg::*;
#(
  parameter int          NUM_PADS    = 38,
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                wbs_cyc_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_PADS-1:0] core_out,
  input  logic [NUM_PADS-1:0] core_oeb,
  output logic [NUM_PADS-1:0] core_in,
  input  logic [NUM_PADS-1:0] io_in,
  output logic [NUM_PADS-1:0] io_out,
  output logic [NUM_PADS-1:0] io_oeb,
  output logic                irq_o
);

  localparam pad_vec_t PAD_MASK = {64{1'b1}} >> (64 - NUM_PADS);

  pad_vec_t sel_q, out_q, oe_q, rise_q, irq_en_q;
  pad_vec_t in_vec, rise_det, rd_vec, wr_mask, wr_data, rise_clr;
  logic [NUM_PADS-1:0] in_sync, rise_raw;
  logic [31:0] byte_mask, rd_word, dat_q;
  logic [5:0]  offset;
  logic [2:0]  reg_idx;
  logic        adr_hi, in_window, mapped, req, start, wr_en, ack_q, irq_q;
  logic        unused_adr;

  pad_sync_edge #(.WIDTH(NUM_PADS), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .d     (io_in),
    .q     (in_sync),
    .rise  (rise_raw)
  );

  // Address decode: the whole 64-byte window acks, only 0x00..0x2F maps.
  assign offset     = wbs_adr_i[5:0];
  assign reg_idx    = offset[5:3];
  assign adr_hi     = offset[2];
  assign in_window  = ((wbs_adr_i ^ BASE_ADDR) & ~(WINDOW_SIZE - 32'd1)) == 32'd0;
  assign mapped     = offset < MAPPED_LIMIT;
  assign req        = wbs_cyc_i && wbs_stb_i && in_window;
  assign start      = req && !ack_q;
  assign wr_en      = start && wbs_we_i && mapped;
  assign unused_adr = ^wbs_adr_i[1:0];

  // Widen the synchronised inputs and place the write lanes in the right half.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    in_vec   = '0;
    rise_det = '0;
    in_vec[NUM_PADS-1:0]   = in_sync;
    rise_det[NUM_PADS-1:0] = rise_raw;
    for (int i = 0; i < 4; i++) byte_mask[i*8 +: 8] = {8{wbs_sel_i[i]}};
    wr_mask  = adr_hi ? {byte_mask, 32'h0} : {32'h0, byte_mask};
    wr_data  = {wbs_dat_i, wbs_dat_i};
    rise_clr = (wr_en && reg_idx == REG_RISE) ? (wr_data & wr_mask) : '0;
  end

  // Read mux for the addressed register half.
  always_comb begin
    rd_vec = '0;
    case (reg_idx)
      REG_SEL:    rd_vec = sel_q;
      REG_OUT:    rd_vec = out_q;
      REG_OE:     rd_vec = oe_q;
      REG_IN:     rd_vec = in_vec;
      REG_RISE:   rd_vec = rise_q;
      REG_IRQ_EN: rd_vec = irq_en_q;
      default:    rd_vec = '0;
    endcase
    rd_word = adr_hi ? rd_vec[63:32] : rd_vec[31:0];
  end

  // Register file; a new edge outranks a same-cycle W1C on RISE.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sel_q    <= '0;
      out_q    <= '0;
      oe_q     <= '0;
      rise_q   <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en && reg_idx == REG_SEL)
        sel_q <= merge_bytes(sel_q, wr_data, wr_mask) & PAD_MASK;
      if (wr_en && reg_idx == REG_OUT)
        out_q <= merge_bytes(out_q, wr_data, wr_mask) & PAD_MASK;
      if (wr_en && reg_idx == REG_OE)
        oe_q <= merge_bytes(oe_q, wr_data, wr_mask) & PAD_MASK;
      if (wr_en && reg_idx == REG_IRQ_EN)
        irq_en_q <= merge_bytes(irq_en_q, wr_data, wr_mask) & PAD_MASK;
      rise_q <= ((rise_q & ~rise_clr) | rise_det) & PAD_MASK;
      irq_q  <= |(rise_q & irq_en_q);
    end
  end

  // One-cycle ack with read data valid only alongside it.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= start;
      dat_q <= (start && !wbs_we_i) ? rd_word : '0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign irq_o     = irq_q;

  // Pad mux: software-owned pads take OUT/OE, the rest pass the core through.
  assign io_out  = (sel_q[NUM_PADS-1:0] & out_q[NUM_PADS-1:0]) |
                   (~sel_q[NUM_PADS-1:0] & core_out);
  assign io_oeb  = (sel_q[NUM_PADS-1:0] & ~oe_q[NUM_PADS-1:0]) |
                   (~sel_q[NUM_PADS-1:0] & core_oeb);
  assign core_in = io_in;

endmodule

// File: tb/tb_wb_pad_ctrl.sv
// Self-checking bench for wb_pad_ctrl with 38 pads at the default base.
module tb_wb_pad_ctrl;

  localparam int          NP   = 38;
  localparam logic [31:0] BASE = 32'h3000_0000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cyc, stb, we;
  logic [3:0]    sel;
  logic [31:0]   adr, wdat;
  logic          ack;
  logic [31:0]   rdat;
  logic [NP-1:0] core_out, core_oeb, core_in, io_in, io_out, io_oeb;
  logic          irq;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        is_wr;
    logic [7:0]  off;
    logic [3:0]  be;
    logic [31:0] dat;
    logic [31:0] exp;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  wb_pad_ctrl #(.NUM_PADS(NP), .BASE_ADDR(BASE), .SYNC_STAGES(2)) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_sel_i (sel),
    .wbs_adr_i (adr),
    .wbs_dat_i (wdat),
    .wbs_ack_o (ack),
    .wbs_dat_o (rdat),
    .core_out  (core_out),
    .core_oeb  (core_oeb),
    .core_in   (core_in),
    .io_in     (io_in),
    .io_out    (io_out),
    .io_oeb    (io_oeb),
    .irq_o     (irq)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Called on a falling edge; returns on the falling edge where ack is seen.
  task automatic wb_xfer(input logic w, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d, output logic got, output logic [31:0] r);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = be; wdat = d;
    got = 1'b0; r = '0;
    for (int i = 0; i < 16 && !got; i++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; r = rdat; end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [3:0] be, input logic [31:0] d);
    logic got; logic [31:0] r;
    wb_xfer(1'b1, BASE + {24'h0, off}, be, d, got, r);
    check($sformatf("ack wr@%02h", off), {63'h0, got}, 64'h1);
  endtask

  task automatic wb_read(input logic [7:0] off, input logic [31:0] e);
    logic got; logic [31:0] r, exp_v;
    sb_q.push_back(e);
    wb_xfer(1'b0, BASE + {24'h0, off}, 4'hF, 32'h0, got, r);
    exp_v = sb_q.pop_front();
    check($sformatf("ack rd@%02h", off), {63'h0, got}, 64'h1);
    if (got) check($sformatf("rd@%02h", off), {32'h0, r}, {32'h0, exp_v});
  endtask

  task automatic add_rd(input logic [7:0] off, input logic [31:0] e);
    tbl.push_back('{1'b0, off, 4'hF, 32'h0, e});
  endtask

  task automatic add_wr(input logic [7:0] off, input logic [3:0] be, input logic [31:0] d);
    tbl.push_back('{1'b1, off, be, d, 32'h0});
  endtask

  initial begin
    logic got; logic [31:0] r;
    int acks, stray;
    logic [NP-1:0] pat;

    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; wdat = 0;
    core_out = 38'h15_5555_AAAA;
    core_oeb = 38'h2A_0F0F_F0F0;
    io_in    = '1;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst ack", {63'h0, ack}, 64'h0);
    check("rst dat", {32'h0, rdat}, 64'h0);
    check("rst irq", {63'h0, irq}, 64'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst io_out", {26'h0, io_out}, {26'h0, core_out});
    check("rst io_oeb", {26'h0, io_oeb}, {26'h0, core_oeb});
    check("core_in", {26'h0, core_in}, {26'h0, io_in});
    check("no false rise", dut.rise_q, 64'h0);

    // Register map with io_in held high, then SEL/OUT/OE and byte lanes.
    add_rd(8'h00, 32'h0);       add_rd(8'h04, 32'h0);
    add_rd(8'h08, 32'h0);       add_rd(8'h0C, 32'h0);
    add_rd(8'h10, 32'h0);       add_rd(8'h14, 32'h0);
    add_rd(8'h18, 32'hFFFF_FFFF); add_rd(8'h1C, 32'h0000_003F);
    add_rd(8'h20, 32'h0);       add_rd(8'h24, 32'h0);
    add_rd(8'h28, 32'h0);       add_rd(8'h2C, 32'h0);
    add_rd(8'h38, 32'h0);
    add_wr(8'h04, 4'hF, 32'hFFFF_FFFF); add_rd(8'h04, 32'h0000_003F);
    add_wr(8'h04, 4'hF, 32'h0);         add_rd(8'h04, 32'h0);
    add_wr(8'h00, 4'hF, 32'h1);
    add_wr(8'h08, 4'hF, 32'h1);
    add_wr(8'h10, 4'hF, 32'h1);
    add_wr(8'h08, 4'b0010, 32'hFFFF_ABFF); add_rd(8'h08, 32'h0000_AB01);
    add_wr(8'h38, 4'hF, 32'hFFFF_FFFF);    add_rd(8'h38, 32'h0);
    add_rd(8'h00, 32'h1);       add_rd(8'h10, 32'h1);
    foreach (tbl[i]) begin
      if (tbl[i].is_wr) wb_write(tbl[i].off, tbl[i].be, tbl[i].dat);
      else              wb_read(tbl[i].off, tbl[i].exp);
    end
    check("sw io_out", {26'h0, io_out}, {26'h0, (core_out & ~38'h1) | 38'h1});
    check("sw io_oeb", {26'h0, io_oeb}, {26'h0, core_oeb & ~38'h1});

    // Rising edge on pad 5: IN at 2, RISE at 3, irq at 4 cycles.
    io_in = '0;
    repeat (5) @(negedge clk);
    wb_write(8'h28, 4'hF, 32'h20);
    io_in[5] = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("IN5 c%0d", k),   {63'h0, dut.in_sync[5]}, {63'h0, k >= 2});
      check($sformatf("RISE5 c%0d", k), {63'h0, dut.rise_q[5]},  {63'h0, k >= 3});
      check($sformatf("irq c%0d", k),   {63'h0, irq},            {63'h0, k >= 4});
    end
    wb_read(8'h20, 32'h20);
    wb_write(8'h20, 4'hF, 32'h20);
    check("irq at w1c ack", {63'h0, irq}, 64'h1);
    @(negedge clk);
    check("irq after w1c", {63'h0, irq}, 64'h0);
    wb_read(8'h20, 32'h0);

    // W1C sampled on the same edge that sets RISE: the set must win.
    io_in[5] = 1'b0;
    repeat (5) @(negedge clk);
    io_in[5] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wb_write(8'h20, 4'hF, 32'h20);
    wb_read(8'h20, 32'h20);
    check("irq coincident", {63'h0, irq}, 64'h1);

    // Outside the window: no ack within the bound.
    wb_xfer(1'b0, BASE + 32'h40, 4'hF, 32'h0, got, r);
    check("no ack outside", {63'h0, got}, 64'h0);

    // Held strobe for six cycles: one ack every two cycles, data only with ack.
    acks = 0; stray = 0;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (ack) acks++;
      else if (rdat != 32'h0) stray++;
    end
    cyc = 1'b0; stb = 1'b0;
    check("held stb acks", 64'(acks), 64'd3);
    check("dat idle zero", 64'(stray), 64'd0);

    pat = {$urandom(), $urandom()};
    io_in = pat;
    #1;
    check("core_in random", {26'h0, core_in}, {26'h0, pat});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_pad_ctrl.md
# wb_pad_ctrl

Parametrised Wishbone-controlled pad multiplexer between the user project wrapper and the core instances behind it. It generalises the fixed one-core-owns-every-pad arrangement to NUM_PADS pads. Each pad can be handed individually to software GPIO, with synchronised input readback, sticky rising-edge capture and a maskable interrupt. It sits on the management SoC Wishbone slave port, in front of the io_in/io_out/io_oeb pad buses.

## Interface
- NUM_PADS, 38: number of pads handled; legal range 1..64.
- BASE_ADDR, 32'h3000_0000: Wishbone base address; the block decodes BASE_ADDR + 0x00..0x2F.
- SYNC_STAGES, 2: input synchroniser depth; minimum 2.
- wb_clk_i  in  1  single clock for all logic.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic cycle controls.
- wbs_sel_i  in  4  write byte enables.
- wbs_adr_i, wbs_dat_i  in  32 each  address and write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data.
- core_out, core_oeb  in  NUM_PADS each  pad drive and active-low enable from the core.
- core_in  out  NUM_PADS  raw io_in passthrough to the core.
- io_in  in  NUM_PADS  pad inputs.
- io_out, io_oeb  out  NUM_PADS each  pad drive and active-low enable.
- irq_o  out  1  level interrupt.

## Operation
- Register file. Each register is 64 bits wide, split into a low word at +0 and a high word at +4. Word offsets are register index × 8.
  - 0 SEL: 1 = software owns the pad.
  - 1 OUT: software drive value.
  - 2 OE: 1 = software drives the pad.
  - 3 IN: synchronised pad value, read-only.
  - 4 RISE: sticky rising-edge flags; writing 1 clears a bit.
  - 5 IRQ_EN: interrupt enable mask.
- Bits at index NUM_PADS and above read 0 and ignore writes. Writes honour wbs_sel_i per byte.
- Pad mux, combinational from registers:
  - io_out[k] = SEL[k] ? OUT[k] : core_out[k].
  - io_oeb[k] = SEL[k] ? ~OE[k] : core_oeb[k].
  - core_in = io_in, always, regardless of SEL.
- Input path:
  - io_in passes through a SYNC_STAGES flop chain to IN, plus one further delay stage prev.
  - A rise is detected when IN & ~prev; a detected rise sets the RISE bit.
  - A rise on a pad with SEL = 0 still sets RISE.
- Interrupt: irq_o = |(RISE & IRQ_EN), driven from a flop.
- Address decode:
  - A transfer is addressed when wbs_adr_i[31:6] == BASE_ADDR[31:6] and offset < 0x30.
  - Unmapped offsets inside the 64-byte window are acknowledged; they read 0 and ignore writes.
  - Addresses outside the window get no ack.

## Timing
- Reset values: all registers 0, synchroniser and prev 0, wbs_ack_o 0, wbs_dat_o 0, irq_o 0. Pads therefore belong to the core out of reset.
- Handshake:
  - wbs_ack_o rises the cycle after cyc & stb & addressed & !ack, and is high for exactly one cycle.
  - A held stb yields one ack per two cycles.
  - wbs_dat_o is valid in the same cycle as the ack and returns to 0 otherwise.
  - A write takes effect on the clock edge that raises ack.
- Read latency is 1 cycle. Pad input to IN is SYNC_STAGES cycles; to RISE, SYNC_STAGES+1; to irq_o, SYNC_STAGES+2.
- A RISE W1C write in the same cycle as a new edge on that bit: set wins, so the bit stays 1.
- Edge detection is suppressed for the first SYNC_STAGES+1 cycles after reset release, via a saturating counter. This prevents false edges on pads that are high at reset.
- Reset asserted mid-transfer: ack drops immediately; the write is lost; the master must retry.
- cyc deasserted while ack is pending: ack is still issued next cycle and ignored by the master. Register state updates only for writes.

## Structure
- Shared package wb_pad_pkg holds:
  - register index constants REG_SEL..REG_IRQ_EN;
  - the window size 0x40;
  - a 64-bit pad-vector typedef.
- One natural sub-module: pad_sync_edge. It is the per-vector synchroniser plus prev stage plus rise detect, parameterised by width and SYNC_STAGES.
- The rest of the block is the register file, decode and mux, all flat.

## Test plan
- Reset with NUM_PADS = 38:
  - io_oeb == core_oeb and io_out == core_out;
  - all reads return 0;
  - no RISE set for io_in held at all-ones through reset release.
- Write SEL_lo = 0x1, OUT_lo = 0x1, OE_lo = 0x1 -> io_out[0] = 1 and io_oeb[0] = 0 the cycle after the final ack; pads 1..37 remain on the core.
- Write 0xFFFF_FFFF to SEL_hi -> read back 0x0000_003F.
- Byte write: sel = 4'b0010, data 0xAB00 to OUT_lo -> only bits 15:8 change.
- Toggle io_in[5] 0 -> 1 with IRQ_EN[5] = 1:
  - IN[5] after 2 cycles, RISE[5] after 3, irq_o after 4;
  - W1C 0x20 clears RISE[5] and drops irq_o the following cycle;
  - W1C coincident with a new edge leaves the bit set.
- Access offset 0x38 -> ack, read 0. Access BASE_ADDR + 0x40 -> no ack in 16 cycles. Held stb for 6 cycles -> exactly 3 acks.
